// File: rtl/cve2_pkg.sv
// Shared types for the RVFI trace buffer.
// Defining CVE2_TRACE_MEM_EN adds the memory-access fields to each trace record.
package cve2_pkg;

    localparam int unsigned TraceOrderW = 64;

    typedef struct packed {
        logic [TraceOrderW-1:0] order;
        logic [31:0]            pc;
        logic [31:0]            insn;
        logic                   trap;
        logic                   intr;
        logic [4:0]             rd_addr;
        logic [31:0]            rd_wdata;
`ifdef CVE2_TRACE_MEM_EN
        logic [31:0]            mem_addr;
        logic [3:0]             mem_rmask;
        logic [3:0]             mem_wmask;
`endif
        logic                   gap;
    } trace_rec_t;

endpackage

// File: rtl/cve2_trace_fifo.sv
// Record storage for the trace buffer: circular array with read/write pointers and occupancy.
// The record layout follows cve2_pkg::trace_rec_t (CVE2_TRACE_MEM_EN widens it).
module cve2_trace_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  trace_rec_t               wdata_i,
    input  logic                     pop_i,
    output trace_rec_t               rdata_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = PtrW + 1;

    trace_rec_t              mem_q [Depth];
    logic [PtrW-1:0]         wptr_q;
    logic [PtrW-1:0]         rptr_q;
    logic [LevelW-1:0]       level_q;

    // Depth is a power of two, so pointer overflow is the modulo-Depth wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while level is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// Captures RVFI retirements into a small FIFO, counting drops and flagging gaps in the stream.
// Define CVE2_TRACE_MEM_EN to capture mem_addr/mem_rmask/mem_wmask into each record.
module cve2_rvfi_trace_buffer
    import cve2_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DropCntW = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     rvfi_valid_i,
    input  logic [63:0]              rvfi_order_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic                     rvfi_trap_i,
    input  logic                     rvfi_intr_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic [31:0]              rvfi_mem_addr_i,
    input  logic [3:0]               rvfi_mem_rmask_i,
    input  logic [3:0]               rvfi_mem_wmask_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output trace_rec_t               trace_rec_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic [DropCntW-1:0]      drop_cnt_o,
    output logic                     overflow_o
);

    localparam int unsigned LevelW = $clog2(Depth) + 1;
    localparam logic [LevelW-1:0] FullLevel = LevelW'(Depth);

    function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                want_push;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                gap_q;
    logic                overflow_q;
    logic [DropCntW-1:0] drop_cnt_q;
    trace_rec_t          wrec;

    assign want_push     = rvfi_valid_i & enable_i & ~clear_i;
    assign full          = (level_o == FullLevel);
    assign trace_valid_o = (level_o != '0);
    assign pop           = trace_valid_o & trace_ready_i;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push          = want_push & (~full | pop);
    assign drop          = want_push & full & ~pop;

    always_comb begin
        wrec          = '0;
        wrec.order    = rvfi_order_i;
        wrec.pc       = rvfi_pc_rdata_i;
        wrec.insn     = rvfi_insn_i;
        wrec.trap     = rvfi_trap_i;
        wrec.intr     = rvfi_intr_i;
        wrec.rd_addr  = rvfi_rd_addr_i;
        wrec.rd_wdata = rvfi_rd_wdata_i;
`ifdef CVE2_TRACE_MEM_EN
        wrec.mem_addr  = rvfi_mem_addr_i;
        wrec.mem_rmask = rvfi_mem_rmask_i;
        wrec.mem_wmask = rvfi_mem_wmask_i;
`endif
        wrec.gap      = gap_q;
    end

`ifndef CVE2_TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
`endif

    cve2_trace_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (wrec),
        .pop_i   (pop),
        .rdata_o (trace_rec_o),
        .level_o (level_o)
    );

    // gap_q marks that the next accepted record follows at least one lost retirement.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            gap_q      <= 1'b0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            overflow_q <= 1'b1;
            gap_q      <= 1'b1;
        end else if (push) begin
            gap_q      <= 1'b0;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Scoreboard bench for cve2_rvfi_trace_buffer: queue-based reference model plus directed and random stimulus.
module tb_cve2_rvfi_trace_buffer;
    import cve2_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DW     = 16;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int DMAX   = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          valid = 1'b0;
    logic          ready = 1'b0;
    logic [63:0]   order = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   insn = '0;
    logic          trap = 1'b0;
    logic          intr = 1'b0;
    logic [4:0]    rd_addr = '0;
    logic [31:0]   rd_wdata = '0;
    logic [31:0]   mem_addr = '0;
    logic [3:0]    rmask = '0;
    logic [3:0]    wmask = '0;
    logic          tv;
    trace_rec_t    trec;
    logic [LW-1:0] lvl;
    logic [DW-1:0] dcnt;
    logic          ovf;

    int            checks = 0;
    int            failures = 0;
    trace_rec_t    mq[$];
    int            m_drop = 0;
    bit            m_ovf = 0;
    bit            m_gap = 0;
    bit            mon_en = 0;
    logic [63:0]   next_order = '0;

    cve2_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntW(DW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (en),
        .clear_i          (clr),
        .rvfi_valid_i     (valid),
        .rvfi_order_i     (order),
        .rvfi_pc_rdata_i  (pc),
        .rvfi_insn_i      (insn),
        .rvfi_trap_i      (trap),
        .rvfi_intr_i      (intr),
        .rvfi_rd_addr_i   (rd_addr),
        .rvfi_rd_wdata_i  (rd_wdata),
        .rvfi_mem_addr_i  (mem_addr),
        .rvfi_mem_rmask_i (rmask),
        .rvfi_mem_wmask_i (wmask),
        .trace_valid_o    (tv),
        .trace_ready_i    (ready),
        .trace_rec_o      (trec),
        .level_o          (lvl),
        .drop_cnt_o       (dcnt),
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic trace_rec_t cur_rec();
        trace_rec_t r;
        r          = '0;
        r.order    = order;
        r.pc       = pc;
        r.insn     = insn;
        r.trap     = trap;
        r.intr     = intr;
        r.rd_addr  = rd_addr;
        r.rd_wdata = rd_wdata;
`ifdef CVE2_TRACE_MEM_EN
        r.mem_addr  = mem_addr;
        r.mem_rmask = rmask;
        r.mem_wmask = wmask;
`endif
        r.gap      = m_gap;
        return r;
    endfunction

    // Reference model: a bounded queue with drop counting, evaluated at each rising edge.
    always @(posedge clk) begin
        trace_rec_t tmp;
        if (!rst_n || clr) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 0;
            m_gap  = 0;
        end else begin
            if (mq.size() != 0 && ready) tmp = mq.pop_front();
            if (valid && en) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(cur_rec());
                    m_gap = 0;
                end else begin
                    m_drop = (m_drop == DMAX) ? DMAX : m_drop + 1;
                    m_ovf  = 1;
                    m_gap  = 1;
                end
            end
        end
    end

    // Monitor: compares the presented head record and status against the model away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", tv, mq.size() != 0);
            chk("level", lvl, mq.size());
            chk("drop_cnt", dcnt, m_drop);
            chk("overflow", ovf, m_ovf);
            if (tv) begin
                checks++;
                if (mq.size() == 0) begin
                    failures++;
                    $display("FAIL head_rec actual=valid required=empty");
                end else if (trec !== mq[0]) begin
                    failures++;
                    $display("FAIL head_rec actual=%h required=%h", trec, mq[0]);
                end
            end
        end
    end

    task automatic step_pc(input bit v, input bit e, input bit c, input bit r,
                           input logic [31:0] pcv, input logic [31:0] insnv);
        valid    = v;
        en       = e;
        clr      = c;
        ready    = r;
        order    = next_order;
        pc       = pcv;
        insn     = insnv;
        trap     = 1'($urandom);
        intr     = 1'($urandom);
        rd_addr  = 5'($urandom);
        rd_wdata = $urandom;
        mem_addr = $urandom;
        rmask    = 4'($urandom);
        wmask    = 4'($urandom);
        if (v) next_order = next_order + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input bit e, input bit c, input bit r);
        step_pc(v, e, c, r, $urandom, $urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;
        step(1, 1, 0, 0);
        rst_n = 1'b1;
        chk("rst_level", lvl, 0);
        chk("rst_valid", tv, 0);
        chk("rst_drop", dcnt, 0);
        chk("rst_ovf", ovf, 0);

        // Single record with one-cycle latency.
        step_pc(1, 1, 0, 1, 32'h80, 32'h00000013);
        chk("first_valid", tv, 1);
        chk("first_pc", trec.pc, 32'h80);
        chk("first_insn", trec.insn, 32'h13);
        chk("first_gap", trec.gap, 0);
        step(0, 1, 0, 1);
        chk("first_level_after_pop", lvl, 0);

        // Overfill by two, then drain in order.
        next_order = '0;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        chk("fill_level", lvl, 8);
        chk("fill_drop", dcnt, 2);
        chk("fill_ovf", ovf, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", trec.order, i);
            step(0, 1, 0, 1);
        end
        chk("drain_level", lvl, 0);

        // Gap marking after drops.
        step(1, 1, 0, 0);
        chk("gap_first", trec.gap, 1);
        step(1, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("gap_second", trec.gap, 0);
        step(0, 1, 0, 1);
        chk("gap_drained", lvl, 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        chk("full_level", lvl, 8);
        step(1, 1, 0, 1);
        chk("full_pushpop_level", lvl, 8);
        chk("full_pushpop_drop", dcnt, 2);

        // Clear with a concurrent push at level 5.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        chk("pre_clear_level", lvl, 5);
        step(1, 1, 1, 0);
        chk("clear_level", lvl, 0);
        chk("clear_drop", dcnt, 0);
        chk("clear_ovf", ovf, 0);
        chk("clear_valid", tv, 0);

        // Enable low blocks pushes without counting drops.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("disabled_level", lvl, 0);
        chk("disabled_drop", dcnt, 0);

        // Random traffic including occasional clears and a mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) rst_n = 1'b0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
            rst_n = 1'b1;
        end

        // Drop counter saturation.
        step(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        for (int i = 0; i < DMAX; i++) step(1, 1, 0, 0);
        chk("sat_reach", dcnt, 16'hFFFF);
        step(1, 1, 0, 0);
        chk("sat_hold", dcnt, 16'hFFFF);
        chk("sat_level", lvl, 8);

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
